fios_mm_ctrl: RTL

- Sequencer for the expanded (non-folded) FIOS Montgomery multiplier array of s cascaded DSP processing elements (PEs).
- On a start request it produces read addresses for the b/p operand word memory, so one word pair per cycle reaches PE 0.
- It generates every per-PE control vector on a fixed PE_DELAY skew, and flags the cycles in which the last PE's RES output carries result words.
- It reports busy/done to the host.

---
 rtl/fios_mm_ctrl.sv | 107 ++++++++++
 1 files changed

// File: rtl/fios_mm_ctrl.sv
// fios_mm_ctrl: sequencer and per-PE control decode for the expanded FIOS Montgomery multiplier array
module fios_mm_ctrl #(
    parameter int s             = 8,
    parameter int DSP_REG_LEVEL = 3,
    parameter int RES_DELAY     = 0
) (
    input  logic                  clock_i,
    input  logic                  reset_n_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  rd_en_o,
    output logic [$clog2(s)-1:0]  rd_addr_o,
    output logic [s-1:0]          a_reg_en_o,
    output logic [s-1:0]          m_reg_en_o,
    output logic [s-1:0][1:0]     mux_A_sel_o,
    output logic [s-1:0][1:0]     mux_B_sel_o,
    output logic [s-1:0][1:0]     mux_C_sel_o,
    output logic [s-1:0]          CREG_en_o,
    output logic [s-1:0][8:0]     OPMODE_o,
    output logic [s-1:0]          RES_delay_en_o,
    output logic [s-1:0]          C_input_delay_en_o,
    output logic                  FIOS_input_sel_o,
    output logic                  res_valid_o,
    output logic [$clog2(s)-1:0]  res_idx_o
);
    localparam int PE_DELAY = (DSP_REG_LEVEL == 1 ? 5 : DSP_REG_LEVEL == 2 ? 6 : 8) + RES_DELAY;
    localparam int CW       = $clog2(2 + (s + 1) * PE_DELAY + s);
    localparam int AW       = $clog2(s);
    localparam int R        = 2 + s * PE_DELAY;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          run;
    logic          act;
    int            k;

    // state and cycle counter register
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // next state: abort wins over everything, start is only looked at in IDLE
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                state_nxt = start_i ? RUN : IDLE;
                cnt_nxt   = '0;
            end
            RUN: begin
                state_nxt = abort_i ? IDLE : (cnt == CW'(R + s - 1)) ? DONE : RUN;
                cnt_nxt   = abort_i ? '0 : (cnt == CW'(R + s - 1)) ? cnt : cnt + 1'b1;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // output decode from registered state/cnt; each PE runs on its own skewed local time k
    always_comb begin
        run                = state == RUN;
        busy_o             = state != IDLE;
        done_o             = state == DONE;
        rd_en_o            = run && cnt < CW'(s);
        rd_addr_o          = rd_en_o ? cnt[AW-1:0] : '0;
        res_valid_o        = run && cnt >= CW'(R);
        res_idx_o          = res_valid_o ? AW'(cnt - CW'(R)) : '0;
        FIOS_input_sel_o   = 1'b0;
        a_reg_en_o         = '0;
        m_reg_en_o         = '0;
        mux_A_sel_o        = '0;
        mux_B_sel_o        = '0;
        mux_C_sel_o        = '0;
        CREG_en_o          = '0;
        OPMODE_o           = '0;
        RES_delay_en_o     = '0;
        C_input_delay_en_o = '0;
        k                  = 0;
        act                = 1'b0;
        for (int i = 0; i < s; i++) begin
            k                     = int'(cnt) - 1 - i * PE_DELAY;
            act                   = run && k >= 0 && k <= s + 1;
            a_reg_en_o[i]         = act && k == 0;
            m_reg_en_o[i]         = act && k == DSP_REG_LEVEL;
            mux_A_sel_o[i]        = (act && k < s) ? 2'd1 : 2'd0;
            mux_B_sel_o[i]        = (act && k < s) ? 2'd1 : 2'd0;
            mux_C_sel_o[i]        = (act && i > 0) ? 2'(DSP_REG_LEVEL - 1) : 2'd0;
            CREG_en_o[i]          = act;
            OPMODE_o[i]           = !act ? 9'h000 : k == 0 ? 9'b000000101 : k <= s ? 9'b110010101 : 9'b110010000;
            RES_delay_en_o[i]     = act && RES_DELAY > 0 && k >= 1;
            C_input_delay_en_o[i] = act && DSP_REG_LEVEL >= 2;
        end
    end
endmodule
